// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: FSM encoding,
// register-zero constant and default sizing.
package hazard_ctrl_pkg;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         DEFAULT_CNT_W       = 16;
    localparam int         DEFAULT_MEM_TIMEOUT = 64;

    // A load in ID/EX feeds a source of the IF/ID instruction; $0 never creates a dependency.
    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: combinational priority decode of
// memory-wait / load-use / flush, memory-wait timeout FSM and event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e  state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic       timeout_reg;

    logic mem_wait;
    logic lu;
    logic fl;
    logic timeout_hit;
    logic act_wait;
    logic act_lu;
    logic act_fl;

    assign mem_wait = dmem_req & ~dmem_ready;
    assign lu       = load_use_hit(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
    assign fl       = branch_taken | jump;

    // The timeout cycle abandons the access, so it falls through to the lower priorities.
    assign timeout_hit = (state_reg == HZ_MEM_WAIT) && mem_wait &&
                         (timer_reg == TMR_W'(MEM_TIMEOUT - 1));

    assign act_wait = mem_wait & ~timeout_hit;
    assign act_lu   = ~act_wait & lu;
    assign act_fl   = ~act_wait & ~lu & fl;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        if (rst_n) begin
            if (act_wait) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
            end else if (act_lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (act_fl) begin
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= HZ_RUN;
            timer_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                HZ_RUN: begin
                    if (mem_wait) begin
                        state_reg <= HZ_MEM_WAIT;
                        timer_reg <= '0;
                    end
                end
                HZ_MEM_WAIT: begin
                    // A withdrawn request also ends the wait so the timer cannot fire spuriously.
                    if (!mem_wait) begin
                        state_reg <= HZ_RUN;
                    end else if (timeout_hit) begin
                        state_reg   <= HZ_RUN;
                        timeout_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TMR_W'(1);
                    end
                end
                default: state_reg <= HZ_RUN;
            endcase
        end
    end

    assign state       = (state_reg == HZ_MEM_WAIT);
    assign mem_timeout = timeout_reg;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (act_lu),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (act_fl),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (act_wait),
        .count (wait_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with 4-bit counters and a 4-cycle memory timeout.
module tb_hazard_ctrl;

    localparam int TB_CW = 4;
    localparam int TB_TO = 4;
    localparam logic [18:0] RESET_VEC = {2'b11, 5'b00000, 12'h000};

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mr;
        logic [4:0] xrt;
        logic       bt;
        logic       jmp;
        logic       req;
        logic       rdy;
    } stim_t;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             jump;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_hold;
    logic             state;
    logic             mem_timeout;
    logic [TB_CW-1:0] stall_cnt;
    logic [TB_CW-1:0] flush_cnt;
    logic [TB_CW-1:0] wait_cnt;
    logic [18:0]      obs;

    int          n_chk;
    int          n_fail;
    logic [18:0] sb[$];

    logic       m_state;
    logic       m_to;
    int         m_timer;
    logic [3:0] m_stall;
    logic [3:0] m_flush;
    logic [3:0] m_wait;

    hazard_ctrl #(.CNT_W(TB_CW), .MEM_TIMEOUT(TB_TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .jump         (jump),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .pipe_hold    (pipe_hold),
        .state        (state),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .wait_cnt     (wait_cnt)
    );

    assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
                  state, mem_timeout, stall_cnt, flush_cnt, wait_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(input int rs, input int rt, input int uses, input int mr,
                                 input int xrt, input int bt, input int jmp,
                                 input int req, input int rdy);
        stim_t s;
        s.rs   = 5'(rs);
        s.rt   = 5'(rt);
        s.uses = 1'(uses);
        s.mr   = 1'(mr);
        s.xrt  = 5'(xrt);
        s.bt   = 1'(bt);
        s.jmp  = 1'(jmp);
        s.req  = 1'(req);
        s.rdy  = 1'(rdy);
        return s;
    endfunction

    task automatic drive(input stim_t s);
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_uses_rt   = s.uses;
        ex_mem_read  = s.mr;
        ex_rt        = s.xrt;
        branch_taken = s.bt;
        jump         = s.jmp;
        dmem_req     = s.req;
        dmem_ready   = s.rdy;
    endtask

    task automatic model_reset();
        m_state = 1'b0;
        m_to    = 1'b0;
        m_timer = 0;
        m_stall = '0;
        m_flush = '0;
        m_wait  = '0;
    endtask

    // Drive one cycle of stimulus after the edge, push the expected outputs, advance the model.
    task automatic step(input stim_t s);
        logic mw, lu, fl, to, aw, al, af;
        @(posedge clk);
        #1;
        drive(s);
        mw = s.req & ~s.rdy;
        lu = s.mr && (s.xrt != 5'd0) && ((s.xrt == s.rs) || (s.uses && (s.xrt == s.rt)));
        fl = s.bt | s.jmp;
        to = m_state && mw && (m_timer == TB_TO - 1);
        aw = mw & ~to;
        al = ~aw & lu;
        af = ~aw & ~lu & fl;
        sb.push_back({~(aw | al), ~(aw | al), af, al, aw, m_state, m_to, m_stall, m_flush, m_wait});
        if (al && m_stall != 4'hF) m_stall = m_stall + 4'd1;
        if (af && m_flush != 4'hF) m_flush = m_flush + 4'd1;
        if (aw && m_wait  != 4'hF) m_wait  = m_wait  + 4'd1;
        if (!m_state) begin
            if (mw) begin
                m_state = 1'b1;
                m_timer = 0;
            end
        end else if (!mw) begin
            m_state = 1'b0;
        end else if (to) begin
            m_state = 1'b0;
            m_to    = 1'b1;
        end else begin
            m_timer = m_timer + 1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(mk(5, 5, 1, 1, 5, 1, 1, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, RESET_VEC);
        end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        n_chk++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected %b", obs, RESET_VEC);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_load_use();
        stim_t v[$];
        logic [18:0] e;
        v.push_back(mk(5, 0, 0, 1, 5, 0, 0, 0, 0));
        v.push_back(mk(5, 0, 0, 0, 5, 0, 0, 0, 0));
        v.push_back(mk(1, 5, 1, 1, 5, 0, 0, 0, 0));
        v.push_back(mk(1, 5, 0, 1, 5, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            step(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_use cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        n_chk++;
        if (stall_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL load_use_count: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_reg_zero();
        stim_t v[$];
        logic [18:0] e;
        pulse_reset();
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            step(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reg_zero cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        n_chk++;
        if ({stall_cnt, flush_cnt, wait_cnt} !== 12'h000) begin
            n_fail++;
            $display("FAIL reg_zero_counts: got %h expected 000", {stall_cnt, flush_cnt, wait_cnt});
        end
    endtask

    task automatic test_branch_priority();
        stim_t v[$];
        logic [18:0] e;
        v.push_back(mk(7, 0, 0, 1, 7, 1, 0, 0, 0));
        v.push_back(mk(7, 0, 0, 0, 7, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            step(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL branch_priority cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        n_chk++;
        if (flush_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL branch_flush_count: got %0d expected 2", flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        stim_t v[$];
        logic [18:0] e;
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(3, 0, 0, 1, 3, 1, 0, 1, 0));
        v.push_back(mk(3, 0, 0, 1, 3, 1, 0, 1, 1));
        v.push_back(mk(3, 0, 0, 0, 3, 0, 0, 0, 0));
        foreach (v[i]) begin
            step(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL mem_wait cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        n_chk++;
        if (wait_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL mem_wait_count: got %0d expected 4", wait_cnt);
        end
    endtask

    task automatic test_timeout();
        stim_t v[$];
        logic [18:0] e;
        pulse_reset();
        for (int k = 0; k < 5; k++) v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            step(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL timeout cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        n_chk++;
        if ({mem_timeout, state, wait_cnt} !== {1'b1, 1'b0, 4'd4}) begin
            n_fail++;
            $display("FAIL timeout_final: got to=%b st=%b wait=%0d expected to=1 st=0 wait=4",
                     mem_timeout, state, wait_cnt);
        end
    endtask

    task automatic test_reset_mid();
        stim_t v[$];
        logic [18:0] e;
        v.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (v[i]) begin
            step(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b expected %b", obs, RESET_VEC);
        end
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        model_reset();
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_saturation();
        logic [18:0] e;
        for (int i = 0; i < 20; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL saturation cyc %0d: got %b expected %b", i, obs, e);
            end
        end
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        e = sb.pop_front();
        n_chk++;
        if (flush_cnt !== 4'd15 || obs !== e) begin
            n_fail++;
            $display("FAIL saturation_final: got flush=%0d obs=%b expected flush=15 obs=%b",
                     flush_cnt, obs, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] e;
        int r;
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            step(mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? 1 : 0, (r < 5) ? 1 : 0, (r < 2) ? 1 : 0));
            @(negedge clk);
            e = sb.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %b expected %b", i, obs, e);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS datapath. It sits beside the IF/ID and ID/EX pipeline registers and drives the PC, IF/ID and ID/EX control inputs. It inserts load-use bubbles, flushes IF/ID on taken branches and jumps, and freezes the pipeline while data memory is not ready. It also keeps saturating event counters for performance debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of each event counter.
- `MEM_TIMEOUT`, default 64: maximum number of consecutive MEM_WAIT cycles before an abort.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs`  in  5  rs field of the instruction in IF/ID.
- `id_rt`  in  5  rt field of the instruction in IF/ID.
- `id_uses_rt`  in  1  the IF/ID instruction reads rt as a source (R-type, beq, sw).
- `ex_mem_read`  in  1  mem_read of the instruction currently in ID/EX.
- `ex_rt`  in  5  rt (load destination) of the instruction in ID/EX.
- `branch_taken`  in  1  a branch resolved taken in ID.
- `jump`  in  1  jump decoded in ID.
- `dmem_req`  in  1  MEM stage is accessing data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  replace IF/ID contents with a nop.
- `idex_bubble`  out  1  load all-zero control fields into ID/EX.
- `pipe_hold`  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- `state`  out  1  0 = RUN, 1 = MEM_WAIT.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cnt`  out  CNT_W  load-use stall cycles.
- `flush_cnt`  out  CNT_W  flush cycles.
- `wait_cnt`  out  CNT_W  memory-wait cycles.

## Operation
Hazard terms:
- `mem_wait` = `dmem_req & !dmem_ready`.
- `lu` = `ex_mem_read & ex_rt != 0 & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt))`.
- `fl` = `branch_taken | jump`.

Priority is `mem_wait` > `lu` > `fl`. Exactly one action applies per cycle:
- **mem_wait:** `pipe_hold`=1, `pc_write`=0, `ifid_write`=0, `idex_bubble`=0, `ifid_flush`=0.
- **lu:** `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
- **fl:** `ifid_flush`=1, `pc_write`=1, `ifid_write`=1.
- **none:** `pc_write`=1, `ifid_write`=1, all other controls 0.

Branch and jump are ignored in a stall cycle. IF/ID is held, so the branch re-evaluates on the next cycle.

FSM:
- RUN → MEM_WAIT when `mem_wait`.
- MEM_WAIT → RUN when `dmem_ready`, or when the wait timer reaches `MEM_TIMEOUT`.
- On timeout: set `mem_timeout` (sticky until reset). `pipe_hold` is forced 0 on that cycle and the access is abandoned.
- The wait timer clears on every entry to MEM_WAIT.

Counters:
- Each counter increments by 1 per cycle in which its action (mem_wait / lu / fl) is the one selected.
- Counters saturate at all-ones and do not wrap.
- A hazard masked by a higher-priority action is not counted.

Reset (`rst_n`=0, asynchronous):
- `state`=RUN, `mem_timeout`=0, all counters 0, wait timer 0.
- Controls during reset: `pc_write`=1, `ifid_write`=1, all others 0.
- Reset asserted mid-wait drops MEM_WAIT immediately.

## Timing
- Control outputs are combinational from the current inputs and `state`, and take effect at the same clock edge. Zero-cycle detection is required for correct bubble insertion.
- A load-use stall lasts exactly one cycle. After the bubble, `ex_mem_read`=0, so `lu` deasserts without any state.
- Counters, `state`, `mem_timeout` and the timer update on the rising edge. Counter values are visible one cycle after the event.
- `dmem_ready`=1 in the entry cycle means no MEM_WAIT and no wait count.
- `state` is registered. Its only purpose is timeout tracking, not gating.

## Structure
- The shared pipeline package holds:
  - the state enum (`HZ_RUN`, `HZ_MEM_WAIT`),
  - the register-zero constant,
  - the default `CNT_W` and `MEM_TIMEOUT` localparams.
- One sub-module, `sat_counter` (parameter width, enable, async active-low clear), instantiated three times.
- The combinational priority decode and the FSM live in `hazard_ctrl`.

## Test plan
- Load `lw $5` in ID/EX with `id_rs`=5 → `pc_write`=0, `ifid_write`=0, `idex_bubble`=1 for one cycle; `stall_cnt` reads 1 on the next cycle.
- `ex_rt`=0 with `ex_mem_read`=1 and `id_rs`=0 → no stall; all counters stay at 0.
- `branch_taken`=1 with `lu` also true → stall only, `flush_cnt` unchanged. Next cycle, `branch_taken`=1 with no hazard → `ifid_flush`=1 and `flush_cnt`=1.
- `dmem_req`=1 with `dmem_ready`=0 for 3 cycles, then 1 → `pipe_hold`=1 for 3 cycles, `state` returns to 0, `wait_cnt`=3.
- `MEM_TIMEOUT`=4 with `dmem_ready` held at 0 → `mem_timeout`=1 after 4 wait cycles and `state`=RUN. The flag stays 1 until `rst_n` is pulsed low mid-run, after which all outputs return to their reset values.
- `CNT_W`=4 with 20 consecutive flushes → `flush_cnt` saturates at 15.
